// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared types for the instruction fetch stage
package rv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DROP
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            fault;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO between fetch and decode
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign count   = cnt;
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A simultaneous pop frees the slot, so a push at full is still accepted.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage feeding decode through a small FIFO
module fetch_unit
    import rv_pkg::*;
#(
    parameter int XLEN  = rv_pkg::XLEN,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_in,
    output logic            pc_en,
    input  logic            flush,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    output logic            if_fault
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;
    logic            push;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic            outstanding;
    logic            credit;

    // Counting the in-flight fetch as occupied guarantees its response always has a slot.
    assign outstanding = (state_q == REQ) || (state_q == WAIT);
    assign credit      = (fifo_count + CW'(outstanding)) < CW'(DEPTH);
    assign imem_addr   = addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        push       = 1'b0;
        push_entry = '0;
        pc_en      = 1'b0;
        imem_req   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rst && !flush && credit) begin
                    addr_d = pc_in;
                    if (pc_in[1:0] != 2'b00) begin
                        push             = 1'b1;
                        push_entry.pc    = pc_in;
                        push_entry.fault = 1'b1;
                        pc_en            = 1'b1;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                // Dropping the request on flush means no grant can land during a redirect.
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    imem_req = 1'b1;
                    if (imem_gnt) begin
                        pc_en   = 1'b1;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_d = IDLE;
                    if (!flush) begin
                        push             = 1'b1;
                        push_entry.pc    = addr_q;
                        push_entry.instr = imem_rdata;
                    end
                end else if (flush) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    fetch_fifo #(
        .DEPTH(DEPTH),
        .WIDTH($bits(fetch_entry_t))
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (if_valid && if_ready),
        .flush     (flush),
        .head      (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign if_valid = !fifo_empty;
    assign if_pc    = head_entry.pc;
    assign if_instr = head_entry.instr;
    assign if_fault = head_entry.fault;

    logic unused_full;
    assign unused_full = fifo_full;

endmodule
